debounce_edge_detect: RTL and testbench

- Conditions a raw asynchronous 1-bit input (push-button, external strobe) before it reaches the clocked D flip-flop stage.
- Synchronises the input through a flop chain and filters bounce with a stable-count FSM.
- Emits a clean registered level plus single-cycle rise/fall pulses, so the downstream register stage samples only glitch-free data.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_edge_detect_sync.sv | 28 ++
 rtl/debounce_edge_detect.sv | 120 ++++++++++++
 tb/tb_debounce_edge_detect.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce / edge-detect block: state encoding
// and default parameter values used by both the RTL and its bench.
package debounce_pkg;

   // Gray-coded so adjacent states differ by one bit and state[1] is the
   // committed output level in every state.
   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      WAIT_HIGH = 2'b01,
      IDLE_HIGH = 2'b11,
      WAIT_LOW  = 2'b10
   } state_e;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/debounce_edge_detect_sync.sv
// Generic N-flop synchroniser for a single asynchronous input.
// Resets to 0; the first flop may go metastable, later stages resolve it.
module sync_chain #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [N-1:0] sync_q;
   logic [N-1:0] sync_d;

   // shift the raw input one stage deeper each cycle
   always_comb begin
      sync_d = {sync_q[N-2:0], d};
   end

   // synchroniser register chain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= sync_d;
   end

   assign q = sync_q[N-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounce and edge detection for a raw asynchronous 1-bit input.
//
//   state     | meaning
//   ----------+-------------------------------------------
//   IDLE_LOW  | output committed low, watching for a 1
//   WAIT_HIGH | candidate 1 being qualified, q still 0
//   IDLE_HIGH | output committed high, watching for a 0
//   WAIT_LOW  | candidate 0 being qualified, q still 1
module debounce_edge_detect
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic                 d_sync;
   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic                 busy_q, busy_d;

   sync_chain #(.N(SYNC_STAGES)) u_sync_d (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (d_sync)
   );

   // next state, stability count and edge pulses
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         IDLE_LOW: begin
            if (d_sync) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!d_sync) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!d_sync) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         WAIT_LOW: begin
            if (d_sync) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
   end

   // FSM, counter and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   // Gray encoding makes state bit 1 the committed level in every state.
   assign q    = state_q[1];
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect: each step drives d 2 ns after a
// clock edge and holds an expected {q,rise,fall,busy} for the next edge.
module tb_debounce_edge_detect;
   import debounce_pkg::*;

   logic clk;
   logic reset;
   logic d;
   logic q, rise, fall, busy;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       d;
      logic [3:0] exp;
   } step_t;

   step_t sb[$];

   debounce_edge_detect #(
      .SYNC_STAGES   (DEF_SYNC_STAGES),
      .STABLE_CYCLES (DEF_STABLE_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q),
      .rise  (rise),
      .fall  (fall),
      .busy  (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100us;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int idx, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {q, rise, fall, busy};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s step=%0d observed(q,rise,fall,busy)=%b expected=%b",
                tag, idx, obs, exp);
      end
   endtask

   task automatic push(input int n, input logic dv, input logic [3:0] exp);
      step_t s;
      s.d   = dv;
      s.exp = exp;
      repeat (n) sb.push_back(s);
   endtask

   // expects to start 2 ns after an edge; leaves time 2 ns after an edge
   task automatic run(input string tag);
      step_t s;
      int    idx = 0;
      while (sb.size() > 0) begin
         s = sb.pop_front();
         d = s.d;
         @(posedge clk);
         #1;
         idx++;
         chk(tag, idx, s.exp);
         #1;
      end
   endtask

   initial begin
      // 1. reset held with d=1, then release with d still 1
      reset = 1'b1;
      d     = 1'b1;
      #1;
      chk("rst_async", 0, 4'b0000);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_hold", i, 4'b0000);
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
      push(2, 1'b1, 4'b0000);
      push(3, 1'b1, 4'b0001);
      push(1, 1'b1, 4'b1100);
      push(2, 1'b1, 4'b1000);
      run("rst_release_rise");

      // return to a low baseline via reset with d=0
      d     = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_to_low", 0, 4'b0000);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      push(3, 1'b0, 4'b0000);
      run("low_quiet");

      // 2. clean rise
      push(2, 1'b1, 4'b0000);
      push(3, 1'b1, 4'b0001);
      push(1, 1'b1, 4'b1100);
      push(2, 1'b1, 4'b1000);
      run("clean_rise");

      // clean fall back to low
      push(2, 1'b0, 4'b1000);
      push(3, 1'b0, 4'b1001);
      push(1, 1'b0, 4'b0010);
      push(2, 1'b0, 4'b0000);
      run("clean_fall");

      // 3. bounce 1,0,1,0 (two cycles each) then 0: no commit
      push(2, 1'b1, 4'b0000);
      push(2, 1'b0, 4'b0001);
      push(2, 1'b1, 4'b0000);
      push(2, 1'b0, 4'b0001);
      push(4, 1'b0, 4'b0000);
      run("bounce_reject");

      // 4. 1 for 20 ns, 0 for 10 ns, then 1 held: one rise, 6 edges after last 0->1
      push(2, 1'b1, 4'b0000);
      push(1, 1'b0, 4'b0001);
      push(1, 1'b1, 4'b0001);
      push(1, 1'b1, 4'b0000);
      push(3, 1'b1, 4'b0001);
      push(1, 1'b1, 4'b1100);
      push(3, 1'b1, 4'b1000);
      run("bounce_settle");

      // 5. from q=1: d=0 for 80 ns then d=1: one fall, then one rise 8 cycles later
      push(2, 1'b0, 4'b1000);
      push(3, 1'b0, 4'b1001);
      push(1, 1'b0, 4'b0010);
      push(2, 1'b0, 4'b0000);
      push(2, 1'b1, 4'b0000);
      push(3, 1'b1, 4'b0001);
      push(1, 1'b1, 4'b1100);
      push(2, 1'b1, 4'b1000);
      run("fall_then_rise");

      // 6. from q=1: d=0, reset asserted mid-cycle during WAIT_LOW
      push(2, 1'b0, 4'b1000);
      push(1, 1'b0, 4'b1001);
      run("pre_reset_wait");
      #3;
      reset = 1'b1;
      #1;
      chk("mid_wait_rst", 0, 4'b0000);
      for (int i = 1; i <= 2; i++) begin
         @(posedge clk);
         #1;
         chk("mid_wait_rst_hold", i, 4'b0000);
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
      push(8, 1'b0, 4'b0000);
      run("post_reset_quiet");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
